// File: rtl/led_lights_pkg.sv
// Shared constants and types for the LED display path.
// Used by the binary-to-BCD front end and the display controller.
package led_lights_pkg;
  localparam int BCD_MAX            = 9999;
  localparam int SEG7_DIGITS        = 4;
  localparam int BCD_SCRATCH_DIGITS = 5;
  localparam int BCD_SCRATCH_W      = 4 * BCD_SCRATCH_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction.
// A BCD digit of 5 or more gets +3 before the shift, so the shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd_seg7.sv
// Sequential double-dabble converter feeding the 7-segment display controller.
// It converts one bit per clock, saturates to 9999 and only updates the outputs when a conversion completes.
module bin_to_bcd_seg7
  import led_lights_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             seg7_valid,
  output logic [3:0]       bcd_data_0,
  output logic [3:0]       bcd_data_1,
  output logic [3:0]       bcd_data_2,
  output logic [3:0]       bcd_data_3
);
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int SHIFT_W = BCD_SCRATCH_W + BIN_W;
  localparam int OUT_W   = 4 * SEG7_DIGITS;

  conv_state_t                r_state;
  conv_state_t                w_state_next;
  logic [BIN_W-1:0]           r_bin;
  logic [BCD_SCRATCH_W-1:0]   r_scratch;
  logic [BCD_SCRATCH_W-1:0]   w_adj;
  logic [SHIFT_W-1:0]         w_shift;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_ovf_pending;
  logic                       r_overflow;
  logic                       r_seg7_valid;
  logic [OUT_W-1:0]           r_bcd;
  logic [15:0]                w_bin_ext;
  logic                       w_last_shift;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_SCRATCH_DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .i_digit (r_scratch[4*gi +: 4]),
        .o_digit (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Shifting the whole concatenation drops the scratch MSB naturally.
  assign w_shift      = {w_adj, r_bin} << 1;
  assign w_bin_ext    = 16'(r_bin);
  assign w_last_shift = (r_state == SHIFT) && (r_cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CHECK;
      CHECK:   w_state_next = SHIFT;
      SHIFT:   if (w_last_shift) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin         <= '0;
      r_scratch     <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_overflow    <= 1'b0;
      r_seg7_valid  <= 1'b0;
      r_bcd         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin     <= bin_in;
            r_scratch <= '0;
            r_cnt     <= '0;
          end
        end
        CHECK: begin
          r_ovf_pending <= (w_bin_ext > 16'(BCD_MAX));
        end
        SHIFT: begin
          r_scratch <= w_shift[SHIFT_W-1 -: BCD_SCRATCH_W];
          r_bin     <= w_shift[BIN_W-1:0];
          r_cnt     <= r_cnt + CNT_W'(1);
          // Results land on the edge entering DONE, together with the done pulse.
          if (w_last_shift) begin
            r_bcd        <= r_ovf_pending ? {SEG7_DIGITS{4'd9}} : w_shift[BIN_W +: OUT_W];
            r_overflow   <= r_ovf_pending;
            r_seg7_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign overflow   = r_overflow;
  assign seg7_valid = r_seg7_valid;
  assign bcd_data_0 = r_bcd[15:12];
  assign bcd_data_1 = r_bcd[11:8];
  assign bcd_data_2 = r_bcd[7:4];
  assign bcd_data_3 = r_bcd[3:0];
endmodule

// File: tb/tb_bin_to_bcd_seg7.sv
// Scoreboard bench for bin_to_bcd_seg7: stimulus pushes expected results with the expected done cycle,
// a monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seg7;
  localparam int BIN_W = 14;

  logic             clk;
  logic             rst;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             seg7_valid;
  logic [3:0]       bcd_data_0;
  logic [3:0]       bcd_data_1;
  logic [3:0]       bcd_data_2;
  logic [3:0]       bcd_data_3;

  typedef struct {
    int d0;
    int d1;
    int d2;
    int d3;
    int ovf;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  bin_to_bcd_seg7 #(.BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .seg7_valid (seg7_valid),
    .bcd_data_0 (bcd_data_0),
    .bcd_data_1 (bcd_data_1),
    .bcd_data_2 (bcd_data_2),
    .bcd_data_3 (bcd_data_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_digits(input string name, input int d0, input int d1, input int d2,
                            input int d3, input int ovf, input int vld);
    chk({name, "_d0"}, int'(bcd_data_0), d0);
    chk({name, "_d1"}, int'(bcd_data_1), d1);
    chk({name, "_d2"}, int'(bcd_data_2), d2);
    chk({name, "_d3"}, int'(bcd_data_3), d3);
    chk({name, "_ovf"}, int'(overflow), ovf);
    chk({name, "_valid"}, int'(seg7_valid), vld);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no pending conversion (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk_digits("result", mon_e.d0, mon_e.d1, mon_e.d2, mon_e.d3, mon_e.ovf, 1);
        $display("done @%0d: %0d%0d%0d%0d ovf=%0d", cyc, bcd_data_0, bcd_data_1,
                 bcd_data_2, bcd_data_3, overflow);
      end
    end
  end

  task automatic push(input int d0, input int d1, input int d2, input int d3, input int ovf);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.d2 = d2; e.d3 = d3; e.ovf = ovf;
    e.cyc = cyc + BIN_W + 2;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic convert(input int val, input int d0, input int d1, input int d2,
                         input int d3, input int ovf);
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(val);
    push(d0, d1, d2, d3, ovf);
    $display("start @%0d: bin_in=%0d", cyc, val);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_done", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
    end
    chk_digits("reset", 0, 0, 0, 0, 0, 0);

    convert(1234, 1, 2, 3, 4, 0);
    convert(0, 0, 0, 0, 0, 0);
    convert(9999, 9, 9, 9, 9, 0);
    convert(10000, 9, 9, 9, 9, 1);
    convert(16383, 9, 9, 9, 9, 1);
    convert(5, 0, 0, 0, 5, 0);

    // A start pulse during a conversion is ignored; outputs hold until done.
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(4321);
    push(4, 3, 2, 1, 0);
    $display("start @%0d: bin_in=4321", cyc);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(8765);
    $display("ignored start @%0d: bin_in=8765", cyc);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_busy", int'(busy), 1);
    chk_digits("hold", 0, 0, 0, 5, 0, 1);
    wait_drain();
    repeat (25) @(negedge clk);

    // start held high: back-to-back conversions every BIN_W+3 cycles.
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        bin_in = BIN_W'(42);
        push(0, 0, 4, 2, 0);
      end else begin
        bin_in = BIN_W'(900);
        push(0, 9, 0, 0, 0);
      end
      $display("start @%0d: bin_in=%0d (held)", cyc, bin_in);
      @(negedge clk);
      if (k == 3) start = 1'b0;
      repeat (BIN_W + 2) @(negedge clk);
    end
    wait_drain();

    // Reset in the middle of a conversion.
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(7777);
    $display("start @%0d: bin_in=7777 (to be reset)", cyc);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_digits("rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_done", int'(done), 0);
    end
    convert(60, 0, 0, 6, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
